eth_phy_10g_tx_test_ctrl: RTL and testbench

ETH_PHY_10G_TX_TEST_CTRL -- requirements
Module: eth_phy_10g_tx_test_ctrl

---
 rtl/eth_phy_10g_tx_test_ctrl.sv | 159 +++++++++++++++
 tb/tb_eth_phy_10g_tx_test_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/eth_phy_10g_tx_test_ctrl.sv
// 10GBASE-R transmit test-mode controller: forwards encoder blocks, then brackets
// a PRBS31 test window with idle runs so no frame is ever cut on entry or exit.
module eth_phy_10g_tx_test_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int IDLE_BLOCKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] encoded_tx_data_in,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr_in,
    output logic [DATA_WIDTH-1:0] encoded_tx_data,
    output logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    output logic                  tx_prbs31_enable,
    input  logic                  cfg_prbs31_req,
    input  logic [31:0]           cfg_prbs31_cycles,
    output logic                  status_prbs31_active,
    output logic                  status_prbs31_done,
    output logic [31:0]           status_prbs31_count
);

    generate
        if (DATA_WIDTH != 64) begin : g_bad_data_width
            $error("eth_phy_10g_tx_test_ctrl: DATA_WIDTH must be 64");
        end
        if (HDR_WIDTH != 2) begin : g_bad_hdr_width
            $error("eth_phy_10g_tx_test_ctrl: HDR_WIDTH must be 2");
        end
        if (IDLE_BLOCKS < 1 || IDLE_BLOCKS > 255) begin : g_bad_idle_blocks
            $error("eth_phy_10g_tx_test_ctrl: IDLE_BLOCKS must be 1..255");
        end
    endgenerate

    localparam logic [DATA_WIDTH-1:0] IDLE_DATA = DATA_WIDTH'(8'h1E);
    localparam logic [HDR_WIDTH-1:0]  IDLE_HDR  = HDR_WIDTH'(2'b10);
    localparam logic [7:0]            IDLE_LAST = 8'(IDLE_BLOCKS - 1);

    typedef enum logic [2:0] {
        ST_PASS,
        ST_DRAIN,
        ST_PRBS,
        ST_EXIT,
        ST_WAIT_IDLE
    } state_t;

    // An abort emits its first exit idle on the same edge it leaves DRAIN/PRBS.
    localparam state_t ABORT_STATE = (IDLE_BLOCKS == 1) ? ST_WAIT_IDLE : ST_EXIT;

    state_t      state_reg;
    logic [7:0]  idle_cnt_reg;
    logic        armed_reg;
    logic [31:0] cycles_reg;
    logic [31:0] count_next;
    logic        in_idle;

    assign in_idle    = (encoded_tx_hdr_in == IDLE_HDR) && (encoded_tx_data_in[7:0] == 8'h1E);
    assign count_next = (&status_prbs31_count) ? status_prbs31_count : status_prbs31_count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg            <= ST_PASS;
            idle_cnt_reg         <= '0;
            armed_reg            <= 1'b1;
            cycles_reg           <= '0;
            encoded_tx_data      <= '0;
            encoded_tx_hdr       <= '0;
            tx_prbs31_enable     <= 1'b0;
            status_prbs31_active <= 1'b0;
            status_prbs31_done   <= 1'b0;
            status_prbs31_count  <= '0;
        end else begin
            status_prbs31_done <= 1'b0;
            if (!cfg_prbs31_req) begin
                armed_reg <= 1'b1;
            end

            case (state_reg)
                ST_PASS: begin
                    encoded_tx_data      <= encoded_tx_data_in;
                    encoded_tx_hdr       <= encoded_tx_hdr_in;
                    tx_prbs31_enable     <= 1'b0;
                    status_prbs31_active <= 1'b0;
                    if (cfg_prbs31_req && armed_reg && in_idle) begin
                        state_reg    <= ST_DRAIN;
                        idle_cnt_reg <= '0;
                    end
                end

                ST_DRAIN: begin
                    encoded_tx_data      <= IDLE_DATA;
                    encoded_tx_hdr       <= IDLE_HDR;
                    tx_prbs31_enable     <= 1'b0;
                    status_prbs31_active <= 1'b0;
                    if (!cfg_prbs31_req) begin
                        state_reg    <= ABORT_STATE;
                        idle_cnt_reg <= 8'd1;
                    end else if (idle_cnt_reg == IDLE_LAST) begin
                        state_reg           <= ST_PRBS;
                        cycles_reg          <= cfg_prbs31_cycles;
                        status_prbs31_count <= '0;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + 8'd1;
                    end
                end

                ST_PRBS: begin
                    encoded_tx_data <= IDLE_DATA;
                    encoded_tx_hdr  <= IDLE_HDR;
                    if (!cfg_prbs31_req) begin
                        tx_prbs31_enable     <= 1'b0;
                        status_prbs31_active <= 1'b0;
                        state_reg            <= ABORT_STATE;
                        idle_cnt_reg         <= 8'd1;
                    end else begin
                        tx_prbs31_enable     <= 1'b1;
                        status_prbs31_active <= 1'b1;
                        status_prbs31_count  <= count_next;
                        if (cycles_reg != 32'd0 && count_next == cycles_reg) begin
                            status_prbs31_done <= 1'b1;
                            armed_reg          <= 1'b0;
                            state_reg          <= ST_EXIT;
                            idle_cnt_reg       <= '0;
                        end
                    end
                end

                ST_EXIT: begin
                    encoded_tx_data      <= IDLE_DATA;
                    encoded_tx_hdr       <= IDLE_HDR;
                    tx_prbs31_enable     <= 1'b0;
                    status_prbs31_active <= 1'b0;
                    if (idle_cnt_reg >= IDLE_LAST) begin
                        state_reg <= ST_WAIT_IDLE;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + 8'd1;
                    end
                end

                ST_WAIT_IDLE: begin
                    tx_prbs31_enable     <= 1'b0;
                    status_prbs31_active <= 1'b0;
                    if (in_idle) begin
                        encoded_tx_data <= encoded_tx_data_in;
                        encoded_tx_hdr  <= encoded_tx_hdr_in;
                        state_reg       <= ST_PASS;
                    end else begin
                        encoded_tx_data <= IDLE_DATA;
                        encoded_tx_hdr  <= IDLE_HDR;
                    end
                end

                default: begin
                    state_reg <= ST_PASS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_tx_test_ctrl.sv
// Bench for eth_phy_10g_tx_test_ctrl: vector table for test-mode entry plus
// hand-written timed, abort, drain-drop and reset sequences through a scoreboard.
module tb_eth_phy_10g_tx_test_ctrl;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
        logic        en;
        logic        act;
        logic        done;
    } out_t;

    typedef struct {
        logic        req;
        logic [1:0]  hdr;
        logic [63:0] data;
        out_t        exp;
    } vec_t;

    localparam logic [63:0] IDLE_IN = 64'h5A5A_0000_0000_001E;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in;
    logic [1:0]  hdr_in;
    logic        req;
    logic [31:0] cycles;
    logic [63:0] tx_data;
    logic [1:0]  tx_hdr;
    logic        tx_en;
    logic        st_active;
    logic        st_done;
    logic [31:0] st_count;

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    out_t exp_q[$];
    vec_t tbl[15];

    always #5 clk = ~clk;

    eth_phy_10g_tx_test_ctrl #(
        .DATA_WIDTH (64),
        .HDR_WIDTH  (2),
        .IDLE_BLOCKS(4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .encoded_tx_data_in  (data_in),
        .encoded_tx_hdr_in   (hdr_in),
        .encoded_tx_data     (tx_data),
        .encoded_tx_hdr      (tx_hdr),
        .tx_prbs31_enable    (tx_en),
        .cfg_prbs31_req      (req),
        .cfg_prbs31_cycles   (cycles),
        .status_prbs31_active(st_active),
        .status_prbs31_done  (st_done),
        .status_prbs31_count (st_count)
    );

    function automatic logic [63:0] rnd();
        return {$urandom, $urandom};
    endfunction

    function automatic out_t mk(input logic [1:0] h, input logic [63:0] d,
                                input logic en, input logic act, input logic done);
        out_t o;
        o.hdr = h; o.data = d; o.en = en; o.act = act; o.done = done;
        return o;
    endfunction

    function automatic out_t idle_o();
        return mk(2'b10, 64'h1E, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic out_t prbs_o(input logic done);
        return mk(2'b10, 64'h1E, 1'b1, 1'b1, done);
    endfunction

    // Drive one block, queue what must appear one edge later, then check it.
    task automatic step(input logic r, input logic rq, input logic [1:0] h,
                        input logic [63:0] d, input out_t e, input string name);
        out_t got;
        out_t want;
        rst = r; req = rq; hdr_in = h; data_in = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {tx_hdr, tx_data, tx_en, st_active, st_done};
        want = exp_q.pop_front();
        chk_cnt++;
        if (got === want) begin
            pass_cnt++;
            $display("%0t %s hdr=%h data=%h en=%b act=%b done=%b", $time, name,
                     tx_hdr, tx_data, tx_en, st_active, st_done);
        end else begin
            $display("FAIL %s: got hdr=%h data=%h en=%b act=%b done=%b, expected hdr=%h data=%h en=%b act=%b done=%b",
                     name, got.hdr, got.data, got.en, got.act, got.done,
                     want.hdr, want.data, want.en, want.act, want.done);
        end
    endtask

    task automatic check_count(input logic [31:0] e, input string name);
        chk_cnt++;
        if (st_count === e) begin
            pass_cnt++;
            $display("%0t %s count=%0d", $time, name, st_count);
        end else begin
            $display("FAIL %s: count got %0d expected %0d", name, st_count, e);
        end
    endtask

    initial begin
        logic [1:0]  h;
        logic [63:0] d;

        // Mid-frame entry: 10 data blocks forwarded, the idle forwarded, then 4 drain idles.
        for (int i = 0; i < 10; i++) begin
            d = rnd();
            tbl[i].req = 1'b1; tbl[i].hdr = 2'b01; tbl[i].data = d;
            tbl[i].exp = mk(2'b01, d, 1'b0, 1'b0, 1'b0);
        end
        tbl[10].req = 1'b1; tbl[10].hdr = 2'b10; tbl[10].data = IDLE_IN;
        tbl[10].exp = mk(2'b10, IDLE_IN, 1'b0, 1'b0, 1'b0);
        for (int i = 11; i < 15; i++) begin
            tbl[i].req = 1'b1; tbl[i].hdr = 2'b01; tbl[i].data = rnd();
            tbl[i].exp = idle_o();
        end

        rst = 1'b1; req = 1'b0; hdr_in = 2'b00; data_in = '0; cycles = 32'd0;
        step(1'b1, 1'b0, 2'b01, rnd(), mk(2'b00, 64'h0, 1'b0, 1'b0, 1'b0), "reset");
        step(1'b1, 1'b1, 2'b10, IDLE_IN, mk(2'b00, 64'h0, 1'b0, 1'b0, 1'b0), "reset");
        check_count(32'd0, "reset_count");

        for (int i = 0; i < 20; i++) begin
            h = 2'($urandom_range(0, 3));
            d = rnd();
            step(1'b0, 1'b0, h, d, mk(h, d, 1'b0, 1'b0, 1'b0), "passthru");
        end

        cycles = 32'd100;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, tbl[i].req, tbl[i].hdr, tbl[i].data, tbl[i].exp, "entry_vec");
        end

        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 2'b01, rnd(), prbs_o(i == 99), "timed_prbs");
        end
        check_count(32'd100, "timed_count");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b01, rnd(), idle_o(), "timed_exit");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b01, rnd(), idle_o(), "timed_wait");
        step(1'b0, 1'b1, 2'b10, IDLE_IN, mk(2'b10, IDLE_IN, 1'b0, 1'b0, 1'b0), "timed_resume");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 2'b10, IDLE_IN, mk(2'b10, IDLE_IN, 1'b0, 1'b0, 1'b0), "no_reentry");
        end
        check_count(32'd100, "count_hold");

        cycles = 32'd0;
        step(1'b0, 1'b0, 2'b10, IDLE_IN, mk(2'b10, IDLE_IN, 1'b0, 1'b0, 1'b0), "rearm");
        step(1'b0, 1'b1, 2'b10, IDLE_IN, mk(2'b10, IDLE_IN, 1'b0, 1'b0, 1'b0), "abort_entry");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b01, rnd(), idle_o(), "abort_drain");
        for (int i = 0; i < 37; i++) begin
            if (i == 2) cycles = 32'd5;
            step(1'b0, 1'b1, 2'b01, rnd(), prbs_o(1'b0), "abort_prbs");
        end
        check_count(32'd37, "abort_count");
        step(1'b0, 1'b0, 2'b01, rnd(), idle_o(), "abort_drop");
        step(1'b0, 1'b1, 2'b01, rnd(), idle_o(), "abort_exit");
        step(1'b0, 1'b0, 2'b01, rnd(), idle_o(), "abort_exit");
        step(1'b0, 1'b0, 2'b01, rnd(), idle_o(), "abort_exit");
        step(1'b0, 1'b0, 2'b01, rnd(), idle_o(), "abort_wait");
        step(1'b0, 1'b0, 2'b10, IDLE_IN, mk(2'b10, IDLE_IN, 1'b0, 1'b0, 1'b0), "abort_resume");
        check_count(32'd37, "abort_count_hold");

        cycles = 32'd0;
        step(1'b0, 1'b1, 2'b10, IDLE_IN, mk(2'b10, IDLE_IN, 1'b0, 1'b0, 1'b0), "drain_entry");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 2'b01, rnd(), idle_o(), "drain_idle");
        step(1'b0, 1'b0, 2'b01, rnd(), idle_o(), "drain_drop");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b01, rnd(), idle_o(), "drain_exit");
        step(1'b0, 1'b0, 2'b01, rnd(), idle_o(), "drain_wait");
        step(1'b0, 1'b0, 2'b10, IDLE_IN, mk(2'b10, IDLE_IN, 1'b0, 1'b0, 1'b0), "drain_resume");
        check_count(32'd37, "drain_count_hold");

        step(1'b0, 1'b1, 2'b10, IDLE_IN, mk(2'b10, IDLE_IN, 1'b0, 1'b0, 1'b0), "rst_entry");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b01, rnd(), idle_o(), "rst_drain");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'b01, rnd(), prbs_o(1'b0), "rst_prbs");
        check_count(32'd5, "rst_prbs_count");
        step(1'b1, 1'b1, 2'b01, rnd(), mk(2'b00, 64'h0, 1'b0, 1'b0, 1'b0), "rst_mid_prbs");
        check_count(32'd0, "rst_count");
        for (int i = 0; i < 3; i++) begin
            d = rnd();
            step(1'b0, 1'b0, 2'b01, d, mk(2'b01, d, 1'b0, 1'b0, 1'b0), "rst_resume");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
